pkt_rx_reader: RTL

//  User-side reader for the MAC packet receive interface, clocked on clk_156m25 (156.25 MHz, 64-bit words).

---
 rtl/pkt_rx_reader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pkt_rx_reader.sv
// MAC receive-side reader: pulls frames with a credit-limited read enable, checks framing,
// flags oversize frames and forwards words through a 2-entry FIFO with statistics.
module pkt_rx_reader #(
   parameter int unsigned MAX_WORDS = 190,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk_156m25,
   input  logic             reset_156m25_n,
   input  logic             pkt_rx_avail,
   output logic             pkt_rx_ren,
   input  logic [63:0]      pkt_rx_data,
   input  logic             pkt_rx_val,
   input  logic             pkt_rx_sop,
   input  logic             pkt_rx_eop,
   input  logic [2:0]       pkt_rx_mod,
   input  logic             pkt_rx_err,
   output logic [63:0]      out_data,
   output logic             out_val,
   output logic             out_sop,
   output logic             out_eop,
   output logic [2:0]       out_mod,
   output logic             out_err,
   input  logic             out_ready,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] framing_err_cnt,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam int unsigned WC_W = $clog2(MAX_WORDS + 2);

   typedef enum logic [1:0] {StIdle, StRead, StGap} state_e;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
   } word_t;

   state_e            state_q, state_d;
   logic              ren_q, ren_d;
   logic              in_frame_q, in_frame_d;
   logic              over_q, over_d;
   logic [WC_W-1:0]   wc_q, wc_d;
   word_t             mem_q [2];
   word_t             mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  ferr_cnt_q, ferr_cnt_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

   logic              push, pop, framing;
   logic [WC_W-1:0]   wc_new;
   logic              over_new;
   word_t             in_word;

   always_comb begin
      state_d     = state_q;
      ren_d       = ren_q;
      in_frame_d  = in_frame_q;
      over_d      = over_q;
      wc_d        = wc_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      ferr_cnt_d  = ferr_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      push        = 1'b0;
      framing     = 1'b0;
      pop         = (cnt_q != 2'd0) && out_ready;

      // Words only belong to a frame while reading; anything else is a protocol violation.
      if (pkt_rx_val) begin
         if (state_q != StRead) begin
            framing = 1'b1;
         end else if (!in_frame_q) begin
            push    = pkt_rx_sop;
            framing = !pkt_rx_sop;
         end else begin
            push    = 1'b1;
            framing = pkt_rx_sop;
         end
      end

      wc_new   = pkt_rx_sop ? WC_W'(1) : (over_q ? wc_q : wc_q + WC_W'(1));
      over_new = (!pkt_rx_sop && over_q) || (wc_new > WC_W'(MAX_WORDS));

      in_word.data = pkt_rx_data;
      in_word.sop  = pkt_rx_sop;
      in_word.eop  = pkt_rx_eop;
      in_word.mod  = pkt_rx_eop ? pkt_rx_mod : 3'd0;
      in_word.err  = pkt_rx_eop && (pkt_rx_err || over_new);

      if (framing) begin
         ferr_cnt_d = ferr_cnt_q + CNT_W'(1);
      end

      if (push) begin
         mem_d[wr_ptr_q] = in_word;
         wr_ptr_d        = !wr_ptr_q;
         wc_d            = wc_new;
         if (pkt_rx_eop && (pkt_rx_mod != 3'd0)) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(pkt_rx_mod);
         end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(8);
         end
         if (pkt_rx_eop) begin
            in_frame_d = 1'b0;
            over_d     = 1'b0;
            if (in_word.err) begin
               err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
         end else begin
            in_frame_d = 1'b1;
            over_d     = over_new;
         end
      end

      if (pop) begin
         rd_ptr_d = !rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

      unique case (state_q)
         StIdle: begin
            ren_d = 1'b0;
            if (pkt_rx_avail && (cnt_q == 2'd0)) begin
               state_d = StRead;
               ren_d   = 1'b1;
            end
         end
         StRead: begin
            if (push && pkt_rx_eop) begin
               state_d = StGap;
               ren_d   = 1'b0;
            end else begin
               // One slot must stay free for every read still in flight.
               ren_d = ({1'b0, cnt_d} + {2'b00, ren_q}) <= 3'd1;
            end
         end
         StGap: begin
            ren_d   = 1'b0;
            state_d = StIdle;
         end
         default: begin
            ren_d   = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state_q     <= StIdle;
         ren_q       <= 1'b0;
         in_frame_q  <= 1'b0;
         over_q      <= 1'b0;
         wc_q        <= '0;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         ferr_cnt_q  <= '0;
         byte_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ren_q       <= ren_d;
         in_frame_q  <= in_frame_d;
         over_q      <= over_d;
         wc_q        <= wc_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         ferr_cnt_q  <= ferr_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   assign pkt_rx_ren      = ren_q;
   assign out_val         = (cnt_q != 2'd0);
   assign out_data        = mem_q[rd_ptr_q].data;
   assign out_sop         = mem_q[rd_ptr_q].sop;
   assign out_eop         = mem_q[rd_ptr_q].eop;
   assign out_mod         = mem_q[rd_ptr_q].mod;
   assign out_err         = mem_q[rd_ptr_q].err;
   assign frame_cnt       = frame_cnt_q;
   assign err_cnt         = err_cnt_q;
   assign framing_err_cnt = ferr_cnt_q;
   assign byte_cnt        = byte_cnt_q;

endmodule
